// File: rtl/uart_apb_pkg.sv
// Shared command codes and state encodings for the UART-to-APB bridge.
package uart_apb_pkg;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] ACK_BYTE  = 8'h4B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_SETUP,
    ST_ACCESS,
    ST_SEND,
    ST_WAIT_TX
  } cmd_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_phy.sv
// 8N1 UART line interface: RXD synchroniser, receive shifter, transmit shifter.
module uart_phy
  import uart_apb_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic       txd_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_load_i,
  output logic       tx_busy_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_ferr_q, rx_ferr_d;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic             txd_q, txd_d;
  logic             tx_busy_q;

  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_ferr_o  = rx_ferr_q;
  assign txd_o      = txd_q;
  assign tx_busy_o  = tx_busy_q;

  // Receive: detect start edge, verify at half bit, then sample each bit centre.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CNT_W'(1);
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync_q && rx_prev_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_M1) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_M1) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_sh_q;
          end else begin
            rx_ferr_d  = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Transmit: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT long.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CNT_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_load_i) begin
          tx_state_d = TX_START;
          tx_sh_d    = tx_data_i;
          txd_d      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_M1) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
          txd_d      = tx_sh_q[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_M1) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            txd_d    = tx_sh_q[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_M1) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // State and datapath registers; line idles high through reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rxd_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
      tx_busy_q  <= (tx_state_d != TX_IDLE);
    end
  end

endmodule

// File: rtl/uart_apb_master.sv
// UART command front-end: decodes R/W byte commands into single APB transfers.
module uart_apb_master
  import uart_apb_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       RXD,
  output logic       TXD,
  output logic       PSEL,
  output logic [7:0] PADDR,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY
);

  cmd_state_e state_q, state_d;
  logic       pwrite_q, pwrite_d;
  logic [7:0] paddr_q, paddr_d;
  logic [7:0] pwdata_q, pwdata_d;
  logic       psel_q, psel_d;
  logic       penable_q, penable_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_load_c;

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr, tx_busy;

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

  uart_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
    .clk_i      (PCLK),
    .rst_i      (PRESET),
    .rxd_i      (RXD),
    .txd_o      (TXD),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ferr_o  (rx_ferr),
    .tx_data_i  (tx_byte_q),
    .tx_load_i  (tx_load_c),
    .tx_busy_o  (tx_busy)
  );

  // Command sequencing; bytes arriving outside the collect states are dropped.
  always_comb begin
    state_d   = state_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    tx_byte_d = tx_byte_q;
    tx_load_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_data == CMD_READ) begin
          pwrite_d = 1'b0;
          state_d  = ST_GET_ADDR;
        end else if (rx_valid && rx_data == CMD_WRITE) begin
          pwrite_d = 1'b1;
          state_d  = ST_GET_ADDR;
        end
      end
      ST_GET_ADDR: begin
        if (rx_ferr) begin
          state_d = ST_IDLE;
        end else if (rx_valid) begin
          paddr_d = rx_data;
          state_d = pwrite_q ? ST_GET_DATA : ST_SETUP;
        end
      end
      ST_GET_DATA: begin
        if (rx_ferr) begin
          state_d = ST_IDLE;
        end else if (rx_valid) begin
          pwdata_d = rx_data;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
          tx_byte_d = pwrite_q ? ACK_BYTE : PRDATA;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_load_c = 1'b1;
          state_d   = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d = (state_d == ST_ACCESS);
  end

  // Command state and APB output registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      tx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      tx_byte_q <= tx_byte_d;
    end
  end

endmodule
